// File: rtl/alu_multicycle.sv
// Execute unit: single-cycle AND/OR/ADD/SUB/SLT, iterative shift-add MUL.
// start/busy/done handshake lets the pipeline stall while a MUL iterates.
module alu_multicycle #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [3:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1111;

  logic [0:0]        state_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [CW-1:0]     cnt_q;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              ovf;
  logic              slt;
  logic [DATA_W-1:0] op_res;
  logic [DATA_W-1:0] acc_nxt;

  always_comb begin
    sum  = src1_i + src2_i;
    diff = src1_i - src2_i;
    // Overflow of A-B: operand signs differ and result sign differs from A.
    ovf  = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) &&
           (diff[DATA_W-1] != src1_i[DATA_W-1]);
    slt  = diff[DATA_W-1] ^ ovf;
    op_res = '0;
    unique case (ctrl_i)
      OP_AND:  op_res = src1_i & src2_i;
      OP_OR:   op_res = src1_i | src2_i;
      OP_ADD:  op_res = sum;
      OP_SUB:  op_res = diff;
      OP_SLT:  op_res = {{(DATA_W-1){1'b0}}, slt};
      default: op_res = '0;
    endcase
  end

  assign acc_nxt = b_q[0] ? (acc_q + a_q) : acc_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_o <= '0;
      zero_o   <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (ctrl_i == OP_MUL) begin
              a_q     <= src1_i;
              b_q     <= src2_i;
              acc_q   <= '0;
              cnt_q   <= '0;
              busy_o  <= 1'b1;
              state_q <= MUL;
            end else begin
              result_o <= op_res;
              zero_o   <= (op_res == '0);
              done_o   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc_q <= acc_nxt;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            result_o <= acc_nxt;
            zero_o   <= (acc_nxt == '0);
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes expectations,
// a negedge monitor pops and compares on every done_o.
module tb_alu_multicycle;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  ctrl_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        busy_o;
  logic        done_o;

  alu_multicycle #(.DATA_W(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] r;
    logic        z;
    int          c;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && done_o === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: done_o=1 at cycle %0d, expected none",
                 cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_result"}, result_o, e.r);
        check({e.name, "_zero"}, {31'b0, zero_o}, {31'b0, e.z});
        check({e.name, "_cycle"}, cyc, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one start cycle; caller is at posedge+1.
  task automatic issue(input string nm, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] r);
    exp_t e;
    start_i = 1'b1;
    ctrl_i  = c;
    src1_i  = a;
    src2_i  = b;
    if (push) begin
      e.name = nm;
      e.r = r;
      e.z = (r == 32'h0);
      e.c = cyc + ((c == 4'b1111) ? 33 : 1);
      q.push_back(e);
    end
    step();
    start_i = 1'b0;
    ctrl_i  = 4'h0;
    src1_i  = 32'h0;
    src2_i  = 32'h0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    int bc;
    rst_i   = 1'b0;
    start_i = 1'b0;
    ctrl_i  = 4'h0;
    src1_i  = 32'h0;
    src2_i  = 32'h0;
    step();
    step();
    rst_i = 1'b1;
    step();
    check("rst_result", result_o, 32'h0);
    check("rst_zero", {31'b0, zero_o}, 32'h1);
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check("rst_done", {31'b0, done_o}, 32'h0);

    issue("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000);
    issue("sub_eq", 4'b0110, 32'd5, 32'd5, 1, 32'h0);
    issue("slt_min", 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 1, 32'h1);
    issue("slt_neg", 4'b0111, 32'h1, 32'hFFFF_FFFF, 1, 32'h0);
    issue("and", 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_F000);
    issue("or", 4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_FFF0);
    drain();

    issue("mul_m1x3", 4'b1111, 32'hFFFF_FFFF, 32'd3, 1, 32'hFFFF_FFFD);
    bc = 0;
    for (int i = 0; i < 33; i++) begin
      if (busy_o) bc++;
      step();
    end
    check("mul_busy_cycles", bc, 32);
    drain();

    issue("mul_wrap", 4'b1111, 32'h0001_0000, 32'h0001_0000, 1, 32'h0);
    drain();

    issue("mul_busy_start", 4'b1111, 32'd7, 32'd6, 1, 32'd42);
    repeat (5) step();
    issue("ignored_add", 4'b0010, 32'd1, 32'd1, 0, 32'h0);
    drain();
    repeat (5) step();

    issue("mul_abort", 4'b1111, 32'd5, 32'd5, 0, 32'h0);
    repeat (9) step();
    rst_i = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy_o}, 32'h0);
    check("abort_result", result_o, 32'h0);
    check("abort_zero", {31'b0, zero_o}, 32'h1);
    check("abort_done", {31'b0, done_o}, 32'h0);
    step();
    rst_i = 1'b1;
    repeat (40) step();
    issue("add_after_rst", 4'b0010, 32'd2, 32'd3, 1, 32'd5);
    drain();

    issue("mul_b2b", 4'b1111, 32'd3, 32'd4, 1, 32'd12);
    repeat (32) step();
    issue("add_b2b", 4'b0010, 32'd1, 32'd2, 1, 32'd3);
    issue("unknown", 4'b0101, 32'h1234_5678, 32'hFFFF_FFFF, 1, 32'h0);
    drain();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
